// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the ROB commit unit: pointer width, commit width and
// the head-pointer increment helper. Also provides fallback definitions of the
// global range macros. Each fallback is used only when no global definition
// exists, so an existing one is never overridden.

`ifndef LREG_RANGE
`define LREG_RANGE 4:0
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 6:0
`endif
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif

package rob_commit_unit_pkg;

  // Number of entries that can retire per cycle.
  localparam int COMMIT_W = 2;

  // Working width of the increment helper. Callers truncate the result to
  // their own pointer width, which gives the modulo-2*depth wrap for free.
  localparam int PTR_MAX_W = 32;

  // Head pointer width: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Advance a pointer by 0, 1 or 2 entries.
  function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] ptr,
                                                   input logic [1:0]           n);
    return ptr + {{(PTR_MAX_W-2){1'b0}}, n};
  endfunction

endpackage

// File: rtl/rob_head_ptr.sv
// ROB head pointer with wrap bit. The pointer advances by the number of
// entries retired this cycle. A flush clears it to zero, and a flush takes
// priority over any increment.

module rob_head_ptr
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_DEPTH = 64,
  parameter int PTR_W     = ptr_width(ROB_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: clear on flush, otherwise add the retire count. Truncation
  // to PTR_W bits makes the index and wrap bit roll over together.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else begin
      ptr_d = PTR_W'(ptr_inc(PTR_MAX_W'(ptr_q), inc));
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_commit_unit.sv
// ROB commit unit. Retires up to two in-order entries per cycle from the
// head of the reorder buffer. Commit, freelist release and ARAT update
// outputs are combinational. The head pointer is registered.
// Optional debug trace and retired-instruction counter: ROB_COMMIT_DEBUG_EN.
//
// Handshake: commits are all-or-nothing. If a lane that could retire needs
// to free an old physical register, release_ready must be high in the same
// cycle. Otherwise neither lane commits and the head entries wait.

module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int ROB_DEPTH = 64,
  localparam int PTR_W    = ptr_width(ROB_DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               head0_valid,
  input  logic               head0_complete,
  input  logic               head1_valid,
  input  logic               head1_complete,
  input  logic [`LREG_RANGE] head0_lrd,
  input  logic [`LREG_RANGE] head1_lrd,
  input  logic [`PREG_RANGE] head0_prd,
  input  logic [`PREG_RANGE] head1_prd,
  input  logic [`PREG_RANGE] head0_old_prd,
  input  logic [`PREG_RANGE] head1_old_prd,
  input  logic               head0_need_to_wb,
  input  logic               head1_need_to_wb,
  input  logic               flush,
  output logic               commit0,
  output logic               commit1,
  output logic [PTR_W-1:0]   head_ptr,
  output logic [1:0]         release_valid,
  output logic [`PREG_RANGE] release_preg0,
  output logic [`PREG_RANGE] release_preg1,
  input  logic               release_ready,
  output logic [1:0]         arat_wen,
  output logic [`LREG_RANGE] arat_lrd0,
  output logic [`LREG_RANGE] arat_lrd1,
  output logic [`PREG_RANGE] arat_prd0,
  output logic [`PREG_RANGE] arat_prd1
`ifdef ROB_COMMIT_DEBUG_EN
  ,
  input  logic [`PC_RANGE]   head0_pc,
  input  logic [`PC_RANGE]   head1_pc,
  input  logic [31:0]        head0_instr,
  input  logic [31:0]        head1_instr,
  input  logic               head0_skip,
  input  logic               head1_skip,
  output logic [1:0]         dbg_commit_valid,
  output logic [`PC_RANGE]   dbg_pc0,
  output logic [`PC_RANGE]   dbg_pc1,
  output logic [31:0]        dbg_instr0,
  output logic [31:0]        dbg_instr1,
  output logic [1:0]         dbg_skip,
  output logic [63:0]        dbg_commit_cnt
`endif
);

  logic       can0;
  logic       can1;
  logic       wb_block;
  logic [1:0] commit_inc;

  // Commit decision. Lane 1 depends on lane 0, so retirement stays in order.
  // A lane that can retire and needs a freelist slot blocks both lanes when
  // the freelist is not ready.
  always_comb begin
    can0          = head0_valid & head0_complete;
    can1          = can0 & head1_valid & head1_complete;
    wb_block      = ~release_ready &
                    ((can0 & head0_need_to_wb) | (can1 & head1_need_to_wb));
    commit0       = can0 & ~flush & ~wb_block;
    commit1       = can1 & ~flush & ~wb_block;
    commit_inc    = {1'b0, commit0} + {1'b0, commit1};
    release_valid = {commit1 & head1_need_to_wb, commit0 & head0_need_to_wb};
    release_preg0 = head0_old_prd;
    release_preg1 = head1_old_prd;
    arat_wen      = {commit1 & head1_need_to_wb, commit0 & head0_need_to_wb};
    arat_lrd0     = head0_lrd;
    arat_lrd1     = head1_lrd;
    arat_prd0     = head0_prd;
    arat_prd1     = head1_prd;
  end

  rob_head_ptr #(
    .ROB_DEPTH (ROB_DEPTH),
    .PTR_W     (PTR_W)
  ) u_head_ptr (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .inc   (commit_inc),
    .ptr   (head_ptr)
  );

`ifdef ROB_COMMIT_DEBUG_EN
  logic [1:0]       dbg_commit_valid_q, dbg_commit_valid_d;
  logic [`PC_RANGE] dbg_pc0_q, dbg_pc0_d;
  logic [`PC_RANGE] dbg_pc1_q, dbg_pc1_d;
  logic [31:0]      dbg_instr0_q, dbg_instr0_d;
  logic [31:0]      dbg_instr1_q, dbg_instr1_d;
  logic [1:0]       dbg_skip_q, dbg_skip_d;
  logic [63:0]      dbg_commit_cnt_q, dbg_commit_cnt_d;

  // Trace capture: snapshot of the head entries and the retire count.
  always_comb begin
    dbg_commit_valid_d = {commit1, commit0};
    dbg_pc0_d          = head0_pc;
    dbg_pc1_d          = head1_pc;
    dbg_instr0_d       = head0_instr;
    dbg_instr1_d       = head1_instr;
    dbg_skip_d         = {head1_skip, head0_skip};
    dbg_commit_cnt_d   = dbg_commit_cnt_q + {62'b0, commit_inc};
  end

  // Trace registers, one cycle behind the commit they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_commit_valid_q <= '0;
      dbg_pc0_q          <= '0;
      dbg_pc1_q          <= '0;
      dbg_instr0_q       <= '0;
      dbg_instr1_q       <= '0;
      dbg_skip_q         <= '0;
      dbg_commit_cnt_q   <= '0;
    end else begin
      dbg_commit_valid_q <= dbg_commit_valid_d;
      dbg_pc0_q          <= dbg_pc0_d;
      dbg_pc1_q          <= dbg_pc1_d;
      dbg_instr0_q       <= dbg_instr0_d;
      dbg_instr1_q       <= dbg_instr1_d;
      dbg_skip_q         <= dbg_skip_d;
      dbg_commit_cnt_q   <= dbg_commit_cnt_d;
    end
  end

  assign dbg_commit_valid = dbg_commit_valid_q;
  assign dbg_pc0          = dbg_pc0_q;
  assign dbg_pc1          = dbg_pc1_q;
  assign dbg_instr0       = dbg_instr0_q;
  assign dbg_instr1       = dbg_instr1_q;
  assign dbg_skip         = dbg_skip_q;
  assign dbg_commit_cnt   = dbg_commit_cnt_q;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed testbench for rob_commit_unit with the default ROB_DEPTH of 64.

module tb_rob_commit_unit;

  localparam int PTR_W = 7;

  logic               clock;
  logic               reset;
  logic               head0_valid, head0_complete, head1_valid, head1_complete;
  logic [`LREG_RANGE] head0_lrd, head1_lrd;
  logic [`PREG_RANGE] head0_prd, head1_prd, head0_old_prd, head1_old_prd;
  logic               head0_need_to_wb, head1_need_to_wb;
  logic               flush;
  logic               commit0, commit1;
  logic [PTR_W-1:0]   head_ptr;
  logic [1:0]         release_valid;
  logic [`PREG_RANGE] release_preg0, release_preg1;
  logic               release_ready;
  logic [1:0]         arat_wen;
  logic [`LREG_RANGE] arat_lrd0, arat_lrd1;
  logic [`PREG_RANGE] arat_prd0, arat_prd1;
`ifdef ROB_COMMIT_DEBUG_EN
  logic [`PC_RANGE]   head0_pc, head1_pc;
  logic [31:0]        head0_instr, head1_instr;
  logic               head0_skip, head1_skip;
  logic [1:0]         dbg_commit_valid;
  logic [`PC_RANGE]   dbg_pc0, dbg_pc1;
  logic [31:0]        dbg_instr0, dbg_instr1;
  logic [1:0]         dbg_skip;
  logic [63:0]        dbg_commit_cnt;
`endif

  int               tests;
  int               fails;
  logic [PTR_W-1:0] exp_ptr;

  rob_commit_unit dut (
    .clock            (clock),
    .reset            (reset),
    .head0_valid      (head0_valid),
    .head0_complete   (head0_complete),
    .head1_valid      (head1_valid),
    .head1_complete   (head1_complete),
    .head0_lrd        (head0_lrd),
    .head1_lrd        (head1_lrd),
    .head0_prd        (head0_prd),
    .head1_prd        (head1_prd),
    .head0_old_prd    (head0_old_prd),
    .head1_old_prd    (head1_old_prd),
    .head0_need_to_wb (head0_need_to_wb),
    .head1_need_to_wb (head1_need_to_wb),
    .flush            (flush),
    .commit0          (commit0),
    .commit1          (commit1),
    .head_ptr         (head_ptr),
    .release_valid    (release_valid),
    .release_preg0    (release_preg0),
    .release_preg1    (release_preg1),
    .release_ready    (release_ready),
    .arat_wen         (arat_wen),
    .arat_lrd0        (arat_lrd0),
    .arat_lrd1        (arat_lrd1),
    .arat_prd0        (arat_prd0),
    .arat_prd1        (arat_prd1)
`ifdef ROB_COMMIT_DEBUG_EN
    ,
    .head0_pc         (head0_pc),
    .head1_pc         (head1_pc),
    .head0_instr      (head0_instr),
    .head1_instr      (head1_instr),
    .head0_skip       (head0_skip),
    .head1_skip       (head1_skip),
    .dbg_commit_valid (dbg_commit_valid),
    .dbg_pc0          (dbg_pc0),
    .dbg_pc1          (dbg_pc1),
    .dbg_instr0       (dbg_instr0),
    .dbg_instr1       (dbg_instr1),
    .dbg_skip         (dbg_skip),
    .dbg_commit_cnt   (dbg_commit_cnt)
`endif
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle;
    head0_valid = 0; head0_complete = 0; head1_valid = 0; head1_complete = 0;
    head0_need_to_wb = 0; head1_need_to_wb = 0;
    head0_lrd = '0; head1_lrd = '0; head0_prd = '0; head1_prd = '0;
    head0_old_prd = '0; head1_old_prd = '0;
    flush = 0; release_ready = 1;
`ifdef ROB_COMMIT_DEBUG_EN
    head0_pc = '0; head1_pc = '0; head0_instr = '0; head1_instr = '0;
    head0_skip = 0; head1_skip = 0;
`endif
  endtask

  task automatic set_heads(input logic v0, input logic c0, input logic w0,
                           input logic v1, input logic c1, input logic w1);
    head0_valid = v0; head0_complete = c0; head0_need_to_wb = w0;
    head1_valid = v1; head1_complete = c1; head1_need_to_wb = w1;
    head0_lrd = 5'd3;  head0_prd = 7'd40; head0_old_prd = 7'd20;
    head1_lrd = 5'd9;  head1_prd = 7'd41; head1_old_prd = 7'd21;
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    tests++;
    if (head_ptr !== 7'd0) begin
      fails++; $display("FAIL reset_ptr: got %0d expected 0", head_ptr);
    end
    // head1 ready but head0 empty: nothing may retire
    set_heads(0, 0, 1, 1, 1, 1);
    #1;
    tests++;
    if ({commit1, commit0, release_valid, arat_wen} !== 6'b0) begin
      fails++; $display("FAIL empty_head_outputs: got c=%b%b rv=%b aw=%b expected all 0",
                        commit1, commit0, release_valid, arat_wen);
    end
    tick();
    tests++;
    if (head_ptr !== 7'd0) begin
      fails++; $display("FAIL empty_head_hold: got %0d expected 0", head_ptr);
    end
    exp_ptr = 7'd0;
  endtask

  task automatic test_dual_commit;
    for (int i = 0; i < 5; i++) begin
      set_heads(1, 1, 1, 0, 0, 0);
      #1;
      tests++;
      if ({commit1, commit0} !== 2'b01) begin
        fails++; $display("FAIL single_step_commit: got %b%b expected 01", commit1, commit0);
      end
      tick();
      exp_ptr = exp_ptr + 7'd1;
      tests++;
      if (head_ptr !== exp_ptr) begin
        fails++; $display("FAIL single_step_ptr: got %0d expected %0d", head_ptr, exp_ptr);
      end
    end
    set_heads(1, 1, 1, 1, 1, 1);
    release_ready = 1;
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b11 || release_valid !== 2'b11 || arat_wen !== 2'b11) begin
      fails++; $display("FAIL dual_commit: got c=%b%b rv=%b aw=%b expected 11/11/11",
                        commit1, commit0, release_valid, arat_wen);
    end
    tests++;
    if (release_preg0 !== 7'd20 || release_preg1 !== 7'd21) begin
      fails++; $display("FAIL dual_release_preg: got %0d,%0d expected 20,21",
                        release_preg0, release_preg1);
    end
    tests++;
    if (arat_lrd0 !== 5'd3 || arat_lrd1 !== 5'd9 || arat_prd0 !== 7'd40 || arat_prd1 !== 7'd41) begin
      fails++; $display("FAIL dual_arat: got lrd %0d,%0d prd %0d,%0d expected 3,9 40,41",
                        arat_lrd0, arat_lrd1, arat_prd0, arat_prd1);
    end
    tick();
    exp_ptr = 7'd7;
    tests++;
    if (head_ptr !== 7'd7) begin
      fails++; $display("FAIL dual_ptr: got %0d expected 7", head_ptr);
    end
  endtask

  task automatic test_partial_commit;
    set_heads(1, 1, 1, 1, 0, 1);
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b01 || release_valid !== 2'b01 || arat_wen !== 2'b01) begin
      fails++; $display("FAIL partial_commit: got c=%b%b rv=%b aw=%b expected 01/01/01",
                        commit1, commit0, release_valid, arat_wen);
    end
    tick();
    exp_ptr = 7'd8;
    tests++;
    if (head_ptr !== 7'd8) begin
      fails++; $display("FAIL partial_ptr: got %0d expected 8", head_ptr);
    end
  endtask

  task automatic test_freelist_stall;
    set_heads(1, 1, 1, 0, 0, 0);
    release_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (commit0 !== 1'b0 || release_valid !== 2'b00 || arat_wen !== 2'b00) begin
        fails++; $display("FAIL stall_commit: got c0=%b rv=%b aw=%b expected 0/00/00",
                          commit0, release_valid, arat_wen);
      end
      tick();
      tests++;
      if (head_ptr !== 7'd8) begin
        fails++; $display("FAIL stall_ptr: got %0d expected 8", head_ptr);
      end
    end
    release_ready = 1;
    #1;
    tests++;
    if (commit0 !== 1'b1 || release_valid !== 2'b01) begin
      fails++; $display("FAIL stall_release: got c0=%b rv=%b expected 1/01", commit0, release_valid);
    end
    tick();
    exp_ptr = 7'd9;
    tests++;
    if (head_ptr !== 7'd9) begin
      fails++; $display("FAIL stall_release_ptr: got %0d expected 9", head_ptr);
    end
  endtask

  task automatic test_all_or_nothing;
    // lane1 needs a slot, freelist busy: lane0 must not retire alone
    set_heads(1, 1, 0, 1, 1, 1);
    release_ready = 0;
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b00) begin
      fails++; $display("FAIL no_partial_retire: got %b%b expected 00", commit1, commit0);
    end
    tick();
    tests++;
    if (head_ptr !== 7'd9) begin
      fails++; $display("FAIL no_partial_ptr: got %0d expected 9", head_ptr);
    end
    // no lane needs a slot: freelist state is irrelevant
    set_heads(1, 1, 0, 1, 1, 0);
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b11 || release_valid !== 2'b00 || arat_wen !== 2'b00) begin
      fails++; $display("FAIL no_wb_commit: got c=%b%b rv=%b aw=%b expected 11/00/00",
                        commit1, commit0, release_valid, arat_wen);
    end
    tick();
    tests++;
    if (head_ptr !== 7'd11) begin
      fails++; $display("FAIL no_wb_ptr: got %0d expected 11", head_ptr);
    end
    // lane1 not a candidate, so its need_to_wb does not gate lane0
    set_heads(1, 1, 0, 1, 0, 1);
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b01) begin
      fails++; $display("FAIL noncandidate_gate: got %b%b expected 01", commit1, commit0);
    end
    tick();
    exp_ptr = 7'd12;
    tests++;
    if (head_ptr !== 7'd12) begin
      fails++; $display("FAIL noncandidate_ptr: got %0d expected 12", head_ptr);
    end
    release_ready = 1;
  endtask

  task automatic test_incomplete_head;
    set_heads(1, 0, 1, 1, 1, 1);
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b00 || release_valid !== 2'b00 || arat_wen !== 2'b00) begin
      fails++; $display("FAIL incomplete_head: got c=%b%b rv=%b aw=%b expected all 0",
                        commit1, commit0, release_valid, arat_wen);
    end
    tick();
    tests++;
    if (head_ptr !== 7'd12) begin
      fails++; $display("FAIL incomplete_ptr: got %0d expected 12", head_ptr);
    end
  endtask

  task automatic test_wrap;
    int guard;
    guard = 0;
    while (exp_ptr[5:0] != 6'd63 && guard < 64) begin
      guard++;
      if (exp_ptr[5:0] <= 6'd61) set_heads(1, 1, 1, 1, 1, 1);
      else                       set_heads(1, 1, 1, 0, 0, 0);
      tick();
      exp_ptr = exp_ptr + ((exp_ptr[5:0] <= 6'd61) ? 7'd2 : 7'd1);
      tests++;
      if (head_ptr !== exp_ptr) begin
        fails++; $display("FAIL advance_ptr: got %0d expected %0d", head_ptr, exp_ptr);
        exp_ptr = head_ptr;
      end
    end
    set_heads(1, 1, 1, 1, 1, 1);
    tick();
    tests++;
    if (head_ptr !== 7'b1_000001) begin
      fails++; $display("FAIL wrap_ptr: got %b expected 1000001", head_ptr);
    end
    exp_ptr = 7'b1_000001;
  endtask

  task automatic test_flush;
    set_heads(1, 1, 1, 1, 1, 1);
    flush = 1;
    #1;
    tests++;
    if ({commit1, commit0} !== 2'b00 || release_valid !== 2'b00 || arat_wen !== 2'b00) begin
      fails++; $display("FAIL flush_commit: got c=%b%b rv=%b aw=%b expected all 0",
                        commit1, commit0, release_valid, arat_wen);
    end
    tick();
    flush = 0;
    exp_ptr = 7'd0;
    tests++;
    if (head_ptr !== 7'd0) begin
      fails++; $display("FAIL flush_ptr: got %0d expected 0", head_ptr);
    end
  endtask

  task automatic test_reset_mid;
    set_heads(1, 1, 1, 1, 1, 1);
    tick(); tick(); tick();
    tests++;
    if (head_ptr !== 7'd6) begin
      fails++; $display("FAIL pre_reset_ptr: got %0d expected 6", head_ptr);
    end
    reset = 1;
    tick();
    tests++;
    if (head_ptr !== 7'd0) begin
      fails++; $display("FAIL mid_reset_ptr: got %0d expected 0", head_ptr);
    end
`ifdef ROB_COMMIT_DEBUG_EN
    tests++;
    if (dbg_commit_valid !== 2'b00 || dbg_commit_cnt !== 64'd0) begin
      fails++; $display("FAIL mid_reset_dbg: got v=%b cnt=%0d expected 00/0",
                        dbg_commit_valid, dbg_commit_cnt);
    end
`endif
    reset = 0;
    drive_idle();
    tick();
    tests++;
    if (head_ptr !== 7'd0) begin
      fails++; $display("FAIL post_reset_ptr: got %0d expected 0", head_ptr);
    end
    exp_ptr = 7'd0;
  endtask

`ifdef ROB_COMMIT_DEBUG_EN
  task automatic test_debug;
    logic [`PC_RANGE] pc;
    logic [31:0]      instr;
    drive_idle();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      set_heads(1, 1, 1, 0, 0, 0);
      pc = 32'h1000 + 32'(i * 4);
      instr = 32'hA000_0000 + 32'(i);
      head0_pc = pc; head0_instr = instr; head0_skip = i[0];
      tick();
      tests++;
      if (dbg_pc0 !== pc || dbg_instr0 !== instr || dbg_commit_valid !== 2'b01 ||
          dbg_skip[0] !== i[0]) begin
        fails++; $display("FAIL dbg_trace: got pc=%h instr=%h v=%b skip=%b expected pc=%h instr=%h v=01 skip0=%b",
                          dbg_pc0, dbg_instr0, dbg_commit_valid, dbg_skip, pc, instr, i[0]);
      end
    end
    drive_idle();
    tick();
    tests++;
    if (dbg_commit_cnt !== 64'd10 || dbg_commit_valid !== 2'b00) begin
      fails++; $display("FAIL dbg_count: got cnt=%0d v=%b expected 10/00",
                        dbg_commit_cnt, dbg_commit_valid);
    end
  endtask
`endif

  // Test sequence and final report
  initial begin
    tests = 0;
    fails = 0;
    exp_ptr = '0;
    reset = 1;
    drive_idle();
    test_reset();
    test_dual_commit();
    test_partial_commit();
    test_freelist_stall();
    test_all_or_nothing();
    test_incomplete_head();
    test_wrap();
    test_flush();
    test_reset_mid();
`ifdef ROB_COMMIT_DEBUG_EN
    test_debug();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 64, number of ROB entries, power of two, 4 or more.
REQ-002 SHALL have localparam PTR_W = log2(ROB_DEPTH)+1, the head pointer including the wrap bit.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 head0_valid, head0_complete, head1_valid, head1_complete  in  1 each  state of ROB entries at head and head+1.
REQ-006 head0_lrd, head1_lrd  in  `LREG_RANGE; head0_prd, head1_prd, head0_old_prd, head1_old_prd  in  `PREG_RANGE.
REQ-007 head0_need_to_wb, head1_need_to_wb  in  1  entry writes an architectural register.
REQ-008 flush  in  1  pipeline flush.
REQ-009 commit0, commit1  out  1  combinational commit strobes, returned to the ROB entries at head and head+1.
REQ-010 head_ptr  out  PTR_W  registered head pointer; low bits index the ROB, MSB is the wrap bit.
REQ-011 release_valid  out  2  per-lane request to return old_prd to the freelist.
REQ-012 release_preg0, release_preg1  out  `PREG_RANGE; release_ready  in  1  freelist accepts both lanes this cycle.
REQ-013 arat_wen  out  2; arat_lrd0, arat_lrd1  out  `LREG_RANGE; arat_prd0, arat_prd1  out  `PREG_RANGE  architectural rename table update.

Function
REQ-014 can0 SHALL be head0_valid & head0_complete.
REQ-015 can1 SHALL be can0 & head1_valid & head1_complete.
REQ-016 Freelist gate: if any candidate lane has need_to_wb=1 and release_ready=0, then commit0=commit1=0 (all-or-nothing, no partial retire).
REQ-017 commit0 = can0 & ~flush & gate; commit1 = can1 & ~flush & gate; commit1 SHALL never assert without commit0.
REQ-018 release_valid[i] = commit_i & head_i_need_to_wb; release_preg_i = head_i_old_prd.
REQ-019 arat_wen[i] = commit_i & head_i_need_to_wb; arat_lrd_i = head_i_lrd; arat_prd_i = head_i_prd.
REQ-020 All commit, release and arat outputs SHALL be zero-latency (same cycle as the inputs).
REQ-021 head_ptr SHALL advance by commit0+commit1 at the clock edge, modulo 2*ROB_DEPTH; the wrap bit toggles when the index passes ROB_DEPTH-1.
REQ-022 Wrap: at index ROB_DEPTH-1 with 2 commits, the next index SHALL be 1 with the wrap bit toggled.
REQ-023 flush SHALL suppress all commits that cycle and set head_ptr to 0 at the next edge; flush wins over commit.
REQ-024 Empty or incomplete head: no outputs asserted, head_ptr held.

Reset
REQ-025 When reset=1 at an edge: head_ptr=0 and all debug registers=0. Combinational outputs SHALL read 0 whenever head0_valid=0.
REQ-026 Reset asserted mid-stream SHALL drop pending state; no commit is replayed after reset.

Configuration
REQ-027 Macro ROB_COMMIT_DEBUG_EN. When defined, the block SHALL add:
- outputs dbg_commit_valid(2), dbg_pc0/1 (`PC_RANGE), dbg_instr0/1 (32), dbg_skip(2), registered one cycle after the commit;
- inputs head0/1_pc, head0/1_instr, head0/1_skip;
- a 64-bit retired-instruction counter dbg_commit_cnt that adds commit0+commit1 each cycle and resets to 0.
When undefined, these ports and registers SHALL be absent, and function SHALL be otherwise identical.

Structure
REQ-028 A shared package SHALL hold the PTR_W computation, the commit-width constant (2) and the pointer-increment function. `PC_RANGE, `LREG_RANGE and `PREG_RANGE SHALL keep their global definitions.
REQ-029 One sub-module, rob_head_ptr, SHALL contain the wrap-bit pointer register with its increment-by-0/1/2 and clear logic. Gate logic SHALL stay in the top level.

Verification
REQ-030 head0 and head1 both valid and complete, need_to_wb=1, release_ready=1, head_ptr=5 -> commit0=commit1=1, release_valid=2'b11, head_ptr=7 next cycle.
REQ-031 head0 complete, head1 valid but incomplete -> commit0=1, commit1=0, head_ptr +1.
REQ-032 head0 complete with need_to_wb=1 and release_ready=0 for 3 cycles, then 1 -> no commit for 3 cycles, then commit on cycle 4.
REQ-033 head_ptr index 63 (wrap 0), two commits -> head_ptr index 1, wrap bit 1.
REQ-034 flush asserted in the same cycle as two committable heads -> commit0=commit1=0, head_ptr=0 next cycle.
REQ-035 With ROB_COMMIT_DEBUG_EN defined, 10 single commits -> dbg_commit_cnt=10, and dbg_pc0 equals each head0_pc one cycle after its commit.
